montgomery_mult_arbiter: RTL and testbench

//  Shares one montgomery multiplier instance between two requesters, for example two

---
 rtl/montgomery_mult_arbiter.sv | 111 +++++++++++
 tb/tb_montgomery_mult_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_mult_arbiter.sv
// rtl/montgomery_mult_arbiter.sv - round-robin arbiter sharing one montgomery multiplier between two requesters
module montgomery_mult_arbiter #(
    parameter int WIDTH   = 512,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req0_m,
    output logic             req0_ready,
    output logic             req0_done,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [WIDTH-1:0] req1_m,
    output logic             req1_ready,
    output logic             req1_done,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_err,
    output logic             mult_start,
    output logic [WIDTH-1:0] mult_a,
    output logic [WIDTH-1:0] mult_b,
    output logic [WIDTH-1:0] mult_m,
    input  logic [WIDTH-1:0] mult_result,
    input  logic             mult_done,
    output logic             busy,
    output logic             owner
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        last;
    logic [15:0] cnt;
    logic        grant0;
    logic        grant1;

    // A lone requester always wins; on contention the one not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_IDLE) begin
            grant0 = req0_valid && (!req1_valid || last);
            grant1 = req1_valid && (!req0_valid || !last);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign mult_start = (state == ST_LAUNCH);
    assign busy       = (state != ST_IDLE);
    assign req0_done  = (state == ST_RESP) && !owner;
    assign req1_done  = (state == ST_RESP) && owner;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            last        <= 1'b1;
            owner       <= 1'b0;
            cnt         <= '0;
            mult_a      <= '0;
            mult_b      <= '0;
            mult_m      <= '0;
            resp_result <= '0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        owner  <= grant1;
                        mult_a <= grant1 ? req1_a : req0_a;
                        mult_b <= grant1 ? req1_b : req0_b;
                        mult_m <= grant1 ? req1_m : req0_m;
                        state  <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion takes priority over a timeout landing in the same cycle.
                    if (mult_done) begin
                        resp_result <= mult_result;
                        resp_err    <= 1'b0;
                        state       <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        resp_result <= '0;
                        resp_err    <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    last  <= owner;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_mult_arbiter.sv
// tb/tb_montgomery_mult_arbiter.sv - randomized scoreboard bench for montgomery_mult_arbiter
module tb_montgomery_mult_arbiter;

    localparam int W  = 32;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         resetn;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req0_m, req1_a, req1_b, req1_m;
    logic         req0_ready, req0_done, req1_ready, req1_done;
    logic [W-1:0] resp_result, mult_a, mult_b, mult_m, mult_result;
    logic         resp_err, mult_start, mult_done, busy, owner;

    int checks = 0;
    int errors = 0;

    // multiplier model state
    int           rem;
    int           lat_cfg;
    bit           hang_cfg;
    bit           stray;
    logic [W-1:0] mres;

    // reference model state
    bit           last_m;
    bit           pend [2];
    logic [W-1:0] op_a [2];
    logic [W-1:0] op_b [2];
    logic [W-1:0] op_m [2];

    montgomery_mult_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_m(req0_m),
        .req0_ready(req0_ready), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_m(req1_m),
        .req1_ready(req1_ready), .req1_done(req1_done),
        .resp_result(resp_result), .resp_err(resp_err),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b), .mult_m(mult_m),
        .mult_result(mult_result), .mult_done(mult_done),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] modmul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        return W'(p % {32'b0, m});
    endfunction

    // One clock; the multiplier model reacts to the arbiter just after the edge.
    task automatic tick();
        logic [63:0] p;
        @(posedge clk);
        #1;
        mult_done   = 1'b0;
        mult_result = $urandom;
        if (stray) begin
            mult_done = 1'b1;
        end else if (mult_start) begin
            rem  = lat_cfg;
            p    = {32'b0, mult_a} * {32'b0, mult_b};
            mres = W'(p % {32'b0, mult_m});
        end else if (rem > 0) begin
            rem--;
            if (rem == 0 && !hang_cfg) begin
                mult_done   = 1'b1;
                mult_result = mres;
            end
        end
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        resetn = 1'b1;
        rem    = 0;
        last_m = 1'b1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
    endtask

    task automatic new_ops(input int n);
        op_a[n] = $urandom;
        op_b[n] = $urandom;
        op_m[n] = $urandom | 32'h1;
    endtask

    task automatic drive_ops();
        req0_a = op_a[0]; req0_b = op_b[0]; req0_m = op_m[0];
        req1_a = op_a[1]; req1_b = op_b[1]; req1_m = op_m[1];
    endtask

    // One complete transaction checked against arbitration order, timing and result.
    task automatic run_op(input bit v0, input bit v1, input int lat, input bit hang);
        int           own;
        int           c;
        int           exp_c;
        bit           exp_err;
        logic [W-1:0] exp_res;
        own     = (v0 && v1) ? (last_m ? 0 : 1) : (v0 ? 0 : 1);
        exp_err = hang || (lat > TO);
        exp_c   = exp_err ? TO + 1 : lat + 1;
        exp_res = exp_err ? '0 : modmul(op_a[own], op_b[own], op_m[own]);
        lat_cfg  = lat;
        hang_cfg = hang;
        drive_ops();
        req0_valid = v0;
        req1_valid = v1;
        #1;
        check_eq("idle_busy", busy, 0);
        check_eq("ready0", req0_ready, own == 0);
        check_eq("ready1", req1_ready, own == 1);
        tick();
        if (own == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        #1;
        check_eq("start", mult_start, 1);
        check_eq("owner", owner, own);
        check_eq("busy", busy, 1);
        check_eq("mult_a", mult_a, op_a[own]);
        check_eq("mult_b", mult_b, op_b[own]);
        check_eq("mult_m", mult_m, op_m[own]);
        check_eq("ready_busy", req0_ready | req1_ready, 0);
        c = 0;
        do begin
            tick();
            c++;
            if (c == 1) check_eq("start_pulse", mult_start, 0);
        end while (!(req0_done || req1_done) && c < 200);
        check_eq("done_cycle", c, exp_c);
        check_eq("done_own", own ? req1_done : req0_done, 1);
        check_eq("done_other", own ? req0_done : req1_done, 0);
        check_eq("mult_a_hold", mult_a, op_a[own]);
        check_eq("resp_err", resp_err, exp_err);
        check_eq("resp_result", resp_result, exp_res);
        last_m    = own[0];
        pend[own] = 1'b0;
        if (v0 && v1) pend[1-own] = 1'b1;
        tick();
        check_eq("post_done", req0_done | req1_done, 0);
        check_eq("post_result", resp_result, exp_res);
    endtask

    initial begin
        int           r;
        logic [W-1:0] held;
        resetn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_m = '0;
        req1_a = '0; req1_b = '0; req1_m = '0;
        mult_done = 1'b0; mult_result = '0;
        rem = 0; lat_cfg = 4; hang_cfg = 1'b0; stray = 1'b0; mres = '0;
        tick();
        apply_reset();
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_owner", owner, 0);
        check_eq("rst_result", resp_result, 0);
        check_eq("rst_err", resp_err, 0);
        check_eq("rst_mult_a", mult_a, 0);
        check_eq("rst_start", mult_start, 0);
        check_eq("rst_done", req0_done | req1_done, 0);

        // single requester, fixed operands
        op_a[0] = 3; op_b[0] = 5; op_m[0] = 7;
        new_ops(1);
        run_op(1, 0, 4, 0);

        // contention from reset: 0,1,0,1
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            if (!pend[0]) new_ops(0);
            if (!pend[1]) new_ops(1);
            run_op(1, 1, 3 + i, 0);
        end

        // randomized traffic including timeouts and hangs
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(1, 3);
            if (!pend[0]) new_ops(0);
            if (!pend[1]) new_ops(1);
            run_op(r[0] | pend[0], r[1] | pend[1], $urandom_range(1, 22),
                   $urandom_range(0, 5) == 0);
        end
        // drain any requester left holding valid
        if (pend[0] || pend[1]) run_op(pend[0], pend[1], 2, 0);

        // timeout and coincidence
        new_ops(0);
        run_op(1, 0, 5, 1);
        new_ops(1);
        run_op(0, 1, TO, 0);

        // stray done while idle
        held = resp_result;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        check_eq("stray_busy", busy, 0);
        check_eq("stray_result", resp_result, held);
        check_eq("stray_done", req0_done | req1_done, 0);

        // reset in the middle of WAIT
        new_ops(1);
        drive_ops();
        req1_valid = 1'b1;
        lat_cfg = 20;
        hang_cfg = 1'b0;
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        tick();
        check_eq("wait_busy", busy, 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        rem = 0;
        last_m = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", req0_done | req1_done, 0);
        check_eq("mid_rst_result", resp_result, 0);
        check_eq("mid_rst_err", resp_err, 0);
        check_eq("mid_rst_owner", owner, 0);
        check_eq("mid_rst_mult_b", mult_b, 0);
        tick();
        check_eq("mid_rst_done2", req0_done | req1_done, 0);
        new_ops(0);
        new_ops(1);
        run_op(1, 1, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
